// File: rtl/commit_tracker.sv
// commit_tracker: opens one instruction window after reset and follows that
// instruction's token through NUM_PIPES stall-able pipelines of NUM_STAGES
// stages. It produces start/started/ended/ended2 bookkeeping, the iend pulse
// that property checkers sample, and a saturating cycle counter.
// Optional feature macro: COMMIT_TRACKER_TIMEOUT_EN. When it is defined, a
// commit after MAX_CYCLES no longer ends the instruction and the timeout flag
// is driven. When it is undefined, timeout is tied low and iend ignores the
// counter.
module commit_tracker #(
    parameter int NUM_PIPES  = 2,
    parameter int NUM_STAGES = 4,
    parameter int CNT_W      = 8,
    parameter int MAX_CYCLES = 50,
    parameter int CNT_SAT    = 132
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            issue,
    input  logic [NUM_PIPES-1:0]            valid_s1,
    input  logic [NUM_PIPES*NUM_STAGES-1:0] stall,
    input  logic [NUM_PIPES-1:0]            commit_sel,
    output logic                            start,
    output logic                            started,
    output logic                            ended,
    output logic                            ended2,
    output logic                            iend,
    output logic [CNT_W-1:0]                cycle_cnt,
    output logic [NUM_PIPES*NUM_STAGES-1:0] occ,
    output logic [NUM_PIPES-1:0]            commit,
    output logic                            timeout
);

    logic             r_start;
    logic             r_started;
    logic             r_ended;
    logic             r_ended2;
    logic [CNT_W-1:0] r_cnt;
    logic [NUM_PIPES-1:0] w_commit;
    logic             w_window;
    logic             w_edcond;
    logic             w_iend;

    assign w_window = r_start | r_started;

    // Per-pipe token tracking: armed injection, stage registers, commit pulse
    genvar gi, gk;
    generate
        for (gi = 0; gi < NUM_PIPES; gi++) begin : g_pipe
            logic                  r_armed;
            logic                  r_commit_p;
            logic                  w_inj;
            logic [NUM_STAGES:1]   w_stall_p;
            logic [NUM_STAGES:1]   w_occ_p;

            assign w_stall_p  = stall[gi*NUM_STAGES +: NUM_STAGES];
            // A token stalled at S1 keeps the pipe armed until it gets in.
            assign w_inj      = (r_start | r_armed) & valid_s1[gi] & ~w_stall_p[1];
            assign w_occ_p[1] = w_inj;

            // Arm on start; the injection itself has priority so a token
            // entering on the start cycle is not injected twice.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_armed <= 1'b0;
                end else if (w_inj) begin
                    r_armed <= 1'b0;
                end else if (r_start) begin
                    r_armed <= 1'b1;
                end
            end

            for (gk = 2; gk <= NUM_STAGES; gk++) begin : g_stage
                logic r_tok;
                // Stage advances only when not stalled; a stalled stage holds its token.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_tok <= 1'b0;
                    end else if (!w_stall_p[gk]) begin
                        r_tok <= w_occ_p[gk-1] & ~w_stall_p[gk-1];
                    end
                end
                assign w_occ_p[gk] = r_tok;
            end

            // Token leaving the last stage produces a one-cycle commit pulse.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_commit_p <= 1'b0;
                end else begin
                    r_commit_p <= w_occ_p[NUM_STAGES] & ~w_stall_p[NUM_STAGES];
                end
            end

            assign w_commit[gi]                      = r_commit_p;
            assign occ[gi*NUM_STAGES +: NUM_STAGES]  = w_occ_p;
        end
    endgenerate

    assign w_edcond = r_started & |(w_commit & commit_sel);

`ifdef COMMIT_TRACKER_TIMEOUT_EN
    logic r_timeout;

    assign w_iend = w_edcond & ~r_ended & ~r_timeout & (r_cnt <= CNT_W'(MAX_CYCLES));

    // Sticky timeout once the open window outlives MAX_CYCLES without ending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else if (r_started && !r_ended && (r_cnt > CNT_W'(MAX_CYCLES))) begin
            r_timeout <= 1'b1;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_iend  = w_edcond & ~r_ended;
    assign timeout = 1'b0;
`endif

    // Window control: a single start pulse per reset, then sticky started.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start   <= 1'b0;
            r_started <= 1'b0;
        end else begin
            r_start   <= w_window ? 1'b0 : issue;
            r_started <= r_started | r_start;
        end
    end

    // End bookkeeping: first qualifying commit ends, a later one sets ended2.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ended  <= 1'b0;
            r_ended2 <= 1'b0;
        end else begin
            r_ended  <= r_ended | w_iend;
            r_ended2 <= r_ended2 | (r_ended & w_edcond);
        end
    end

    // Cycle counter runs from start and saturates; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_window && (r_cnt < CNT_W'(CNT_SAT))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign start     = r_start;
    assign started   = r_started;
    assign ended     = r_ended;
    assign ended2    = r_ended2;
    assign iend      = w_iend;
    assign cycle_cnt = r_cnt;
    assign commit    = w_commit;

endmodule

// File: doc/commit_tracker.md
# commit_tracker

Parametrised instruction-commit tracker for ILA-vs-RTL refinement wrappers of the L2 cache. It issues one instruction window after reset and follows that instruction's token through NUM_PIPES stall-able pipelines of NUM_STAGES stages each. It flags commit on selected pipes and produces the start/started/ended/second-ended bookkeeping plus a bounded cycle counter. Property checkers compare ILA state against RTL state at `iend`. The block generalises the fixed two-pipe monitor with per-pipe armed injection and an explicit timeout.

## Interface
- NUM_PIPES, 2, number of tracked pipelines (1..8)
- NUM_STAGES, 4, stages per pipeline, S1..S{NUM_STAGES} (2..8)
- CNT_W, 8, cycle counter width
- MAX_CYCLES, 50, last cycle count at which a commit still ends the instruction
- CNT_SAT, 132, counter saturation value (< 2^CNT_W, > MAX_CYCLES)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- issue  in  1  request to start the instruction window
- valid_s1  in  NUM_PIPES  per-pipe S1 valid
- stall  in  NUM_PIPES*NUM_STAGES  stall of pipe p stage k at bit p*NUM_STAGES+(k-1)
- commit_sel  in  NUM_PIPES  pipes whose commit ends the instruction
- start  out  1  one-cycle window start pulse
- started  out  1  sticky, window open
- ended  out  1  sticky, instruction ended
- ended2  out  1  sticky, second qualifying commit after end
- iend  out  1  combinational end pulse
- cycle_cnt  out  CNT_W  cycles since start, saturating
- occ  out  NUM_PIPES*NUM_STAGES  token-occupancy flags, same bit layout as stall
- commit  out  NUM_PIPES  registered per-pipe commit pulse
- timeout  out  1  sticky, window exceeded MAX_CYCLES without end

## Operation
- All outputs reset to 0. `rst` mid-operation clears all state within the same cycle edge, and the block may issue again after reset.
- Window control:
  - `start` <= 0 if start|started, else issue.
  - `started` <= 1 once start is high.
  - Only one window opens per reset.
- Armed injection:
  - `armed[p]` is set on `start`.
  - `armed[p]` clears when inj[p] = (start|armed[p]) & valid_s1[p] & ~stall[p,1].
  - A token stalled at S1 on the start cycle is therefore not lost.
- Token pipeline, per pipe:
  - occ[p,1] = inj[p], combinational.
  - Stage k ≥ 2 register loads occ[p,k-1] & ~stall[p,k-1] only when ~stall[p,k]; otherwise it holds.
  - commit[p] <= occ[p,N] & ~stall[p,N], unconditionally each cycle.
- End logic:
  - edcond = started & |(commit & commit_sel).
  - iend = edcond & ~ended & (cycle_cnt ≤ MAX_CYCLES).
  - ended <= 1 on iend.
  - ended2 <= 1 on ended & edcond & ~ended2.
  - Commits on unselected pipes are visible on `commit` but never end the instruction.
  - Several selected pipes committing in the same cycle produce one iend.
- Counter: cycle_cnt increments while (start|started) & cycle_cnt < CNT_SAT, then holds at CNT_SAT. It is never cleared except by rst.
- Timeout: set when started & ~ended & cycle_cnt > MAX_CYCLES. Once set, no later iend occurs.

## Timing
- Issue held high from cycle 0: start=1 at cycle 1, started=1 at cycle 2, cycle_cnt=1 at cycle 2.
- Stall-free path, injection in cycle t: occ S_k in cycle t+k-1, commit in cycle t+N, iend in cycle t+N, ended in cycle t+N+1.
- Each cycle stall[p,k] is high adds one cycle of latency for a token at stage k. Upstream stages are not blocked by the tracker itself; RTL stalls are assumed consistent.
- A commit at exactly cycle_cnt == MAX_CYCLES ends the instruction. At MAX_CYCLES+1, timeout rises the next cycle.

## Configuration
- COMMIT_TRACKER_TIMEOUT_EN defined: MAX_CYCLES bound applies to iend, and `timeout` is driven as specified.
- COMMIT_TRACKER_TIMEOUT_EN undefined: iend ignores cycle_cnt, `timeout` is tied to 0, and the counter still runs and saturates.

## Test plan
- NUM_PIPES=2, NUM_STAGES=4, commit_sel=2'b01, issue=1, valid_s1[0]=1, no stalls: inj at cycle 1, commit[0]=1 and iend=1 at cycle 5, ended=1 at cycle 6.
- Same setup with stall[0,1]=1 in cycles 1-3: armed holds, injection at cycle 4, iend at cycle 8, cycle_cnt=7 at iend.
- stall[0,3]=1 for 2 cycles while token is at S3: commit delayed by exactly 2 cycles; occ[0,3] stays high during the stall.
- commit_sel=2'b01, pipe 1 committing only: commit[1] pulses, iend never fires; with TIMEOUT_EN, timeout=1 once cycle_cnt=51.
- Both pipes committing on the same cycle with commit_sel=2'b11: single iend. A second selected commit later sets ended2.
- rst asserted at cycle 3 mid-flight: all outputs 0 at cycle 4. Re-issue reproduces the first scenario's timing offset by 4.
